f8_ifetch: RTL and testbench
============================

Name: f8_ifetch

Overview:
Instruction fetch unit for the f8 core. It is the initiator on the memory subsystem's instruction read port: it drives iread_addr and consumes the 3-byte iread_data/iread_valid responses. Fetched bytes are queued, and up to 3 bytes, aligned to the current instruction, are presented to the decoder. It handles branch redirects and replays any request the memory answers with iread_valid=0, which is how read-port conflicts are resolved.

Parameters:
RESET_PC, 16'h0000, fetch address after reset.
BUF_BYTES, 8, byte-queue capacity. Must be >= 9 for full throughput; legal range 3..15.

Ports:
clk  in  1  sole clock, rising edge.
reset  in  1  synchronous, active-high.
iread_addr  out  16  instruction read address; registered.
iread_data  in  24  bytes at addr, addr+1, addr+2 in [7:0], [15:8], [23:16].
iread_valid  in  1  response for the address sampled at the previous edge is good.
out_bytes  out  24  first 3 queued bytes; byte 0 in [7:0].
out_count  out  2  number of valid bytes in out_bytes, saturating at 3.
out_pc  out  16  address of out_bytes[7:0].
consume  in  2  bytes the decoder retires this cycle (0..3).
jump_en  in  1  redirect request.
jump_addr  in  16  redirect target.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset).
- Reset values: queue empty, out_count=0, out_bytes=0, out_pc=RESET_PC, iread_addr=RESET_PC, no requests outstanding. The first request is presented in the cycle after reset deasserts.
- Memory timing:
  - The memory samples iread_addr at edge E.
  - Data and iread_valid for that address are visible in the cycle after E.
  - The fetcher absorbs the response at edge E+1.
  - Up to 2 requests are in flight: one being presented, one returning.
- Request tracking: a per-slot valid bit marks whether the presented address is a real request.
- Issue rule: a new request at fetch_pc is presented only if occupancy after this edge, plus 3 × (outstanding requests including the new one), is <= BUF_BYTES.
- Address advance: fetch_pc += 3 per issued request, modulo 2^16. A 0xFFFF→0x0000 wrap is legal and not flagged.
- Response, iread_valid=1: push 3 bytes at the queue tail.
- Response, iread_valid=0 (replay):
  - Drop the response.
  - Squash the younger in-flight request.
  - Rewind fetch_pc to the failed address and re-present it next cycle.
  - Queue contents are untouched.
- Consume:
  - Pop `consume` bytes from the head; out_pc += consume, modulo 2^16.
  - If consume > out_count, clamp to out_count. This is a decoder bug, never fatal.
- Same-edge push and pop are both applied. Occupancy = old − pop + push, never exceeding BUF_BYTES by construction.
- jump_en, highest priority:
  - At the edge: flush the queue and set out_count=0.
  - Set out_pc=jump_addr and fetch_pc=jump_addr.
  - Invalidate all in-flight requests; their responses are ignored regardless of iread_valid.
  - Ignore consume for this edge.
  - The new request is presented in the following cycle.
  - First bytes at the target appear 2 cycles after the jump edge.
- reset asserted mid-operation overrides everything and returns all state to reset values at that edge. In-flight responses are discarded.
- out_bytes lanes beyond out_count are don't-care for the decoder; the bench checks only valid lanes.
- Steady state with BUF_BYTES>=9, always-valid memory and consume=3 every cycle: out_count=3 on every cycle after fill.

Decomposition:
- Shared package f8_pkg:
  - F8_ADDR_W=16.
  - F8_INSN_MAX=3 (maximum instruction length in bytes).
  - F8_FETCH_BYTES=3 (bytes per instruction read).
- One sub-module, f8_byte_queue:
  - Circular byte FIFO, depth BUF_BYTES.
  - 3-byte push, 0..3-byte pop.
  - Flush input, occupancy output, head-3 window output.
- f8_ifetch holds request tracking, the issue/credit logic, replay/squash and pc registers.

Test Plan:
- Reset, then 3 idle cycles; memory byte at A = A[7:0], iread_valid always 1, consume=0 -> out_pc=0000, out_count=3, out_bytes=24'h020100. iread_addr stops advancing once the queue is full (occupancy 6 with BUF_BYTES=8). No overflow.
- Stream with BUF_BYTES=9, consume=3 every cycle once out_count=3 -> out_pc increments 0,3,6,9…; out_bytes = {pc+2,pc+1,pc} every cycle with no bubbles.
- Force iread_valid=0 for the response to 0x0003 -> 0x0003 is re-presented one cycle later, the younger 0x0006 request is squashed, and the byte sequence at the decoder is unchanged, just delayed.
- jump_en with jump_addr=0x1234 while 2 requests are in flight and consume=2 -> out_count=0 next cycle; iread_addr=0x1234; 2 cycles later out_pc=0x1234, out_bytes=24'h363534. Stale responses are never queued.
- Start at 0xFFFE, consume 1 per cycle -> out_pc sequence FFFE, FFFF, 0000, 0001. Bytes are FE, FF, 00, 01.
- consume=3 while out_count=1 -> only 1 byte popped and out_pc += 1. Assert reset mid-stream -> next cycle all outputs equal their reset values.

Source files
------------

// File: rtl/f8_pkg.sv
// Shared f8 fetch-path types and constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package f8_pkg;

    localparam int F8_ADDR_W      = 16;
    localparam int F8_INSN_MAX    = 3;  // longest instruction, bytes
    localparam int F8_FETCH_BYTES = 3;  // bytes returned per instruction read

    typedef logic [F8_ADDR_W-1:0] f8_addr_t;

    // One instruction-read slot: address plus "this is a real request".
    typedef struct packed {
        logic     vld;
        f8_addr_t addr;
    } f8_req_t;

    // Bytes visible to the decoder: occupancy saturated at one instruction.
    function automatic logic [1:0] f8_sat_insn(input logic [3:0] n);
        return (n >= 4'(F8_INSN_MAX)) ? 2'(F8_INSN_MAX) : n[1:0];
    endfunction

endpackage

// File: rtl/f8_byte_queue.sv
// Circular byte FIFO: 3-byte push, 0..3-byte pop, flush, head-3 window.
// Latency: push visible at the head window the cycle after the push edge.
// Backpressure: none; caller guarantees pop <= occupancy and no overflow.
//
// Ports: clk/reset (sync, active-high); flush empties the queue; push_vld/
// push_dat write 3 bytes at the tail; pop retires bytes at the head;
// occ is the current occupancy; win_dat is the first 3 bytes, byte 0 low.
module f8_byte_queue
    import f8_pkg::*;
#(
    parameter int BUF_BYTES = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          push_vld,
    input  logic [8*F8_FETCH_BYTES-1:0]   push_dat,
    input  logic [1:0]                    pop,
    output logic [3:0]                    occ,
    output logic [8*F8_INSN_MAX-1:0]      win_dat
);

    localparam logic [4:0] DEPTH = 5'(BUF_BYTES);

    // Storage spans the full pointer range; entries at or above BUF_BYTES
    // are never addressed because every pointer wraps at DEPTH.
    logic [7:0] mem [16];
    logic [3:0] head;
    logic [3:0] cnt;
    logic [3:0] tail0, tail1, tail2;
    logic [3:0] head1, head2;
    logic [3:0] cnt_nxt;

    // Modulo-DEPTH pointer add; both operands are < DEPTH + 3, so a single
    // conditional subtract is enough.
    function automatic logic [3:0] wrap(input logic [3:0] base, input logic [3:0] off);
        logic [4:0] s;
        s = {1'b0, base} + {1'b0, off};
        if (s >= DEPTH) begin
            s = s - DEPTH;
        end
        return s[3:0];
    endfunction

    always_comb begin
        tail0   = wrap(head, cnt);
        tail1   = wrap(tail0, 4'd1);
        tail2   = wrap(tail0, 4'd2);
        head1   = wrap(head, 4'd1);
        head2   = wrap(head, 4'd2);
        cnt_nxt = cnt - 4'(pop) + (push_vld ? 4'(F8_FETCH_BYTES) : 4'd0);
        occ     = cnt;
        win_dat = {mem[head2], mem[head1], mem[head]};
    end

    // A same-edge pop lets the tail wrap onto head slots being retired now;
    // those bytes are gone after this edge, so the overwrite is harmless.
    always_ff @(posedge clk) begin
        if (reset) begin
            head <= '0;
            cnt  <= '0;
            for (int i = 0; i < 16; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            cnt <= '0;
        end else begin
            if (push_vld) begin
                mem[tail0] <= push_dat[7:0];
                mem[tail1] <= push_dat[15:8];
                mem[tail2] <= push_dat[23:16];
            end
            head <= wrap(head, {2'b00, pop});
            cnt  <= cnt_nxt;
        end
    end

endmodule

// File: rtl/f8_ifetch.sv
// f8 instruction fetch: issues 3-byte reads, queues bytes, feeds the decoder.
// Latency: request presented 1 cycle after issue; bytes at decoder 2 edges later.
// Backpressure: reads issue only while queue space covers all in-flight data.
//
// Ports: clk/reset (sync, active-high); iread_addr/iread_data/iread_valid is
// the memory read port (iread_valid=0 asks for a replay); out_bytes/out_count/
// out_pc present the head of the byte queue; consume retires decoder bytes;
// jump_en/jump_addr redirect fetch and flush everything in flight.
module f8_ifetch
    import f8_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          BUF_BYTES = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic [F8_ADDR_W-1:0]         iread_addr,
    input  logic [8*F8_FETCH_BYTES-1:0]  iread_data,
    input  logic                         iread_valid,
    output logic [8*F8_INSN_MAX-1:0]     out_bytes,
    output logic [1:0]                   out_count,
    output logic [F8_ADDR_W-1:0]         out_pc,
    input  logic [1:0]                   consume,
    input  logic                         jump_en,
    input  logic [F8_ADDR_W-1:0]         jump_addr
);

    // pres_q: address the memory samples at the next edge.
    // ret_q:  address sampled at the previous edge; its data is on the bus now.
    f8_req_t  pres_q, ret_q;
    f8_addr_t fetch_pc_q, out_pc_q;

    logic [3:0] occ;
    logic [1:0] pop;
    logic       rsp_ok, rsp_replay, pres_live, issue;
    f8_addr_t   issue_addr;
    logic [5:0] occ_nxt, credit_need;

    always_comb begin
        out_count  = f8_sat_insn(occ);
        pop        = jump_en ? 2'd0 : ((consume > out_count) ? out_count : consume);
        rsp_ok     = ret_q.vld & iread_valid & ~jump_en;
        rsp_replay = ret_q.vld & ~iread_valid & ~jump_en;
        // The presented request survives into the return slot unless a jump
        // kills it or an older replay squashes it (it would arrive out of order).
        pres_live  = pres_q.vld & ~jump_en & ~rsp_replay;
        issue_addr = jump_en ? jump_addr : (rsp_replay ? ret_q.addr : fetch_pc_q);
        occ_nxt    = jump_en ? 6'd0
                   : 6'(occ) - 6'(pop) + (rsp_ok ? 6'(F8_FETCH_BYTES) : 6'd0);
        // Reserve space for every read that could still land: the surviving
        // presented one plus the candidate new one.
        credit_need = occ_nxt + (pres_live ? 6'(2 * F8_FETCH_BYTES) : 6'(F8_FETCH_BYTES));
        issue       = (credit_need <= 6'(BUF_BYTES));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pres_q     <= {1'b0, RESET_PC};
            ret_q      <= '0;
            fetch_pc_q <= RESET_PC;
            out_pc_q   <= RESET_PC;
        end else begin
            ret_q.vld  <= pres_live;
            ret_q.addr <= pres_q.addr;
            pres_q.vld <= issue;
            if (issue) begin
                pres_q.addr <= issue_addr;
                fetch_pc_q  <= issue_addr + 16'(F8_FETCH_BYTES);
            end else begin
                // Hold the rewound/redirected address until credit allows.
                fetch_pc_q  <= issue_addr;
            end
            out_pc_q <= jump_en ? jump_addr : out_pc_q + 16'(pop);
        end
    end

    f8_byte_queue #(
        .BUF_BYTES (BUF_BYTES)
    ) u_queue (
        .clk      (clk),
        .reset    (reset),
        .flush    (jump_en),
        .push_vld (rsp_ok),
        .push_dat (iread_data),
        .pop      (pop),
        .occ      (occ),
        .win_dat  (out_bytes)
    );

    assign iread_addr = pres_q.addr;
    assign out_pc     = out_pc_q;

endmodule

// File: tb/tb_f8_ifetch.sv
module tb_f8_ifetch;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    // Main DUT (BUF_BYTES=9, full throughput) and a fill-limit DUT (BUF_BYTES=8).
    logic [15:0] ia9, ia8, pc9, pc8, jaddr;
    logic [23:0] rd9, rd8, ob9, ob8;
    logic [1:0]  cnt9, cnt8, cons;
    logic        jmp, vld9;
    logic [15:0] a9_q, a8_q, bad_addr;
    int          bad_tok = 0, used_tok = 0;
    int          total = 0, bad = 0;

    function automatic logic [23:0] mem_rd(input logic [15:0] a);
        logic [15:0] a1, a2;
        a1 = a + 16'd1;
        a2 = a + 16'd2;
        return {a2[7:0], a1[7:0], a[7:0]};
    endfunction

    // Memory model: sample the address at the edge, answer in the next cycle.
    always @(posedge clk) begin
        a9_q <= ia9;
        a8_q <= ia8;
        if (a9_q == bad_addr && bad_tok != used_tok) used_tok <= bad_tok;
    end
    assign rd9  = mem_rd(a9_q);
    assign rd8  = mem_rd(a8_q);
    assign vld9 = !(a9_q == bad_addr && bad_tok != used_tok);

    f8_ifetch #(.RESET_PC(16'h0000), .BUF_BYTES(9)) u9 (
        .clk(clk), .reset(reset), .iread_addr(ia9), .iread_data(rd9),
        .iread_valid(vld9), .out_bytes(ob9), .out_count(cnt9), .out_pc(pc9),
        .consume(cons), .jump_en(jmp), .jump_addr(jaddr));

    f8_ifetch #(.RESET_PC(16'h0000), .BUF_BYTES(8)) u8 (
        .clk(clk), .reset(reset), .iread_addr(ia8), .iread_data(rd8),
        .iread_valid(1'b1), .out_bytes(ob8), .out_count(cnt8), .out_pc(pc8),
        .consume(2'd0), .jump_en(1'b0), .jump_addr(16'h0000));

    typedef struct {
        logic        rst;
        logic [1:0]  cons;
        logic        jmp;
        logic [15:0] jaddr;
        logic        arm;      // fail the next response for address 0x0003
        logic [1:0]  cnt;
        logic [15:0] pc;
        logic [1:0]  lanes;    // low byte lanes of out_bytes to compare
        logic [23:0] bytes_;
        logic [15:0] ia;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic rst, input logic [1:0] c, input logic j,
                                input logic [15:0] ja, input logic arm,
                                input logic [1:0] n, input logic [15:0] pc,
                                input logic [1:0] lanes, input logic [23:0] b,
                                input logic [15:0] ia);
        vec_t v;
        v.rst = rst; v.cons = c; v.jmp = j; v.jaddr = ja; v.arm = arm;
        v.cnt = n; v.pc = pc; v.lanes = lanes; v.bytes_ = b; v.ia = ia;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic chk_bytes(input string nm, input logic [23:0] got,
                             input logic [1:0] lanes, input logic [23:0] exp);
        logic [23:0] m;
        m = (lanes == 2'd3) ? 24'hFFFFFF : (lanes == 2'd2) ? 24'h00FFFF : 24'h0000FF;
        if (lanes != 2'd0) chk(nm, 32'(got & m), 32'(exp & m));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk9(input string tag, input logic [1:0] n, input logic [15:0] pc,
                        input logic [1:0] lanes, input logic [23:0] b);
        chk({tag, " cnt"}, 32'(cnt9), 32'(n));
        chk({tag, " pc"}, 32'(pc9), 32'(pc));
        chk_bytes({tag, " bytes"}, ob9, lanes, b);
    endtask

    initial begin
        reset = 1'b1; cons = 2'd0; jmp = 1'b0; jaddr = 16'h0; bad_addr = 16'h0003;

        // Reset values on both instances.
        repeat (2) step();
        chk9("rst9", 2'd0, 16'h0000, 2'd3, 24'h000000);
        chk("rst9 ia", 32'(ia9), 32'h0);
        chk("rst8 cnt", 32'(cnt8), 32'h0);
        chk("rst8 bytes", 32'(ob8), 32'h0);
        chk("rst8 ia", 32'(ia8), 32'h0);

        // BUF_BYTES=8 fill: first bytes after 3 edges, fetch stops at occupancy 6.
        reset = 1'b0;
        repeat (3) step();
        chk("fill8 cnt", 32'(cnt8), 32'd3);
        chk("fill8 pc", 32'(pc8), 32'h0);
        chk("fill8 bytes", 32'(ob8), 32'h020100);
        chk("fill8 ia", 32'(ia8), 32'h0003);
        repeat (6) step();
        chk("hold8 ia", 32'(ia8), 32'h0003);
        chk("hold8 bytes", 32'(ob8), 32'h020100);
        chk("hold8 pc", 32'(pc8), 32'h0);

        // Streaming, full queue, replay of 0x0003, jump with two in flight.
        vt.push_back(mk(1,0,0,16'h0,0, 0,16'h0000,3,24'h000000,16'h0000));
        vt.push_back(mk(1,0,0,16'h0,0, 0,16'h0000,3,24'h000000,16'h0000));
        vt.push_back(mk(0,0,0,16'h0,0, 0,16'h0000,0,24'h000000,16'h0000));
        vt.push_back(mk(0,0,0,16'h0,0, 0,16'h0000,0,24'h000000,16'h0003));
        vt.push_back(mk(0,0,0,16'h0,0, 3,16'h0000,3,24'h020100,16'h0006));
        vt.push_back(mk(0,3,0,16'h0,0, 3,16'h0003,3,24'h050403,16'h0009));
        vt.push_back(mk(0,3,0,16'h0,0, 3,16'h0006,3,24'h080706,16'h000C));
        vt.push_back(mk(0,3,0,16'h0,0, 3,16'h0009,3,24'h0B0A09,16'h000F));
        vt.push_back(mk(0,3,0,16'h0,0, 3,16'h000C,3,24'h0E0D0C,16'h0012));
        vt.push_back(mk(0,0,0,16'h0,0, 3,16'h000C,3,24'h0E0D0C,16'h0012));
        vt.push_back(mk(0,0,0,16'h0,0, 3,16'h000C,3,24'h0E0D0C,16'h0012));
        vt.push_back(mk(0,3,0,16'h0,0, 3,16'h000F,3,24'h11100F,16'h0015));
        vt.push_back(mk(0,3,0,16'h0,0, 3,16'h0012,3,24'h141312,16'h0018));
        vt.push_back(mk(0,3,0,16'h0,0, 3,16'h0015,3,24'h171615,16'h001B));
        vt.push_back(mk(1,0,0,16'h0,0, 0,16'h0000,3,24'h000000,16'h0000));
        vt.push_back(mk(0,0,0,16'h0,1, 0,16'h0000,0,24'h000000,16'h0000));
        vt.push_back(mk(0,0,0,16'h0,0, 0,16'h0000,0,24'h000000,16'h0003));
        vt.push_back(mk(0,0,0,16'h0,0, 3,16'h0000,3,24'h020100,16'h0006));
        vt.push_back(mk(0,0,0,16'h0,0, 3,16'h0000,3,24'h020100,16'h0003));
        vt.push_back(mk(0,0,0,16'h0,0, 3,16'h0000,3,24'h020100,16'h0006));
        vt.push_back(mk(0,3,0,16'h0,0, 3,16'h0003,3,24'h050403,16'h0009));
        vt.push_back(mk(0,3,0,16'h0,0, 3,16'h0006,3,24'h080706,16'h000C));
        vt.push_back(mk(0,3,0,16'h0,0, 3,16'h0009,3,24'h0B0A09,16'h000F));
        vt.push_back(mk(0,2,1,16'h1234,0, 0,16'h1234,0,24'h000000,16'h1234));
        vt.push_back(mk(0,0,0,16'h0,0, 0,16'h1234,0,24'h000000,16'h1237));
        vt.push_back(mk(0,0,0,16'h0,0, 3,16'h1234,3,24'h363534,16'h123A));
        vt.push_back(mk(0,3,0,16'h0,0, 3,16'h1237,3,24'h393837,16'h123D));

        foreach (vt[i]) begin
            reset = vt[i].rst;
            cons  = vt[i].cons;
            jmp   = vt[i].jmp;
            jaddr = vt[i].jaddr;
            if (vt[i].arm) begin
                bad_addr = 16'h0003;
                bad_tok++;
            end
            step();
            chk9($sformatf("row%0d", i), vt[i].cnt, vt[i].pc, vt[i].lanes, vt[i].bytes_);
            chk($sformatf("row%0d ia", i), 32'(ia9), 32'(vt[i].ia));
        end
        jmp = 1'b0; cons = 2'd0;

        // Address wrap through 0xFFFF, one byte per cycle.
        jmp = 1'b1; jaddr = 16'hFFFE;
        step();
        chk9("wrap j", 2'd0, 16'hFFFE, 2'd0, 24'h0);
        chk("wrap j ia", 32'(ia9), 32'hFFFE);
        jmp = 1'b0;
        step();
        chk("wrap ia1", 32'(ia9), 32'h0001);
        step();
        chk9("wrap fill", 2'd3, 16'hFFFE, 2'd3, 24'h00FFFE);
        cons = 2'd1;
        step();
        chk9("wrap c1", 2'd3, 16'hFFFF, 2'd1, 24'h0000FF);
        step();
        chk9("wrap c2", 2'd3, 16'h0000, 2'd1, 24'h000000);
        step();
        chk9("wrap c3", 2'd3, 16'h0001, 2'd1, 24'h000001);

        // Starve the queue with a replay so out_count=1, then over-consume.
        cons = 2'd0; jmp = 1'b1; jaddr = 16'h0100;
        bad_addr = 16'h0103; bad_tok++;
        step();
        jmp = 1'b0;
        repeat (2) step();
        chk9("clamp fill", 2'd3, 16'h0100, 2'd3, 24'h020100);
        cons = 2'd2;
        step();
        chk9("clamp one", 2'd1, 16'h0102, 2'd1, 24'h000002);
        chk("clamp replay ia", 32'(ia9), 32'h0103);
        cons = 2'd3;
        step();
        chk9("clamp pop", 2'd0, 16'h0103, 2'd0, 24'h0);
        cons = 2'd0;
        step();
        chk9("clamp refill", 2'd3, 16'h0103, 2'd3, 24'h050403);

        // Reset mid-stream with requests in flight.
        reset = 1'b1;
        step();
        chk9("mrst", 2'd0, 16'h0000, 2'd3, 24'h000000);
        chk("mrst ia", 32'(ia9), 32'h0);
        reset = 1'b0;
        step();
        chk("mrst+1 cnt", 32'(cnt9), 32'h0);
        chk("mrst+1 ia", 32'(ia9), 32'h0);
        step();
        chk("mrst+2 cnt", 32'(cnt9), 32'h0);
        step();
        chk9("mrst+3", 2'd3, 16'h0000, 2'd3, 24'h020100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
